pulse_indicator: RTL and testbench
==================================

PULSE_INDICATOR -- requirements
Module: pulse_indicator

Interface
REQ-001 Parameter ON_CYCLES, default 8: cycles L stays high per event; legal range 1..2^24.
REQ-002 Parameter GAP_CYCLES, default 4: minimum low cycles between consecutive events; legal range 1..2^24.
REQ-003 Parameter MAX_PEND, default 7: pending-event capacity; legal range 1..255.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 P  input  1  one-cycle event pulse, e.g. a button-press pulse or a line-clear pulse.
REQ-007 L  output  1  human-visible level, high for ON_CYCLES per event; drives an LED.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 pend  output  8  count of queued events not yet displayed.
REQ-010 ovf  output  1  sticky flag: an event was lost because the queue was full.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and GAP. L=1 only in ON, and busy=(state!=IDLE).
REQ-012 In IDLE, when P=1 at an edge, the FSM SHALL enter ON and load the cycle counter with ON_CYCLES-1. L rises in the cycle after P is sampled (1-cycle latency).
REQ-013 In ON, the counter SHALL decrement each cycle. At a counter value of 0, the FSM SHALL enter GAP and load GAP_CYCLES-1, so L is high for exactly ON_CYCLES cycles.
REQ-014 In GAP, the counter SHALL decrement each cycle. At 0: if pend>0, or P=1 that cycle, the FSM SHALL enter ON with ON_CYCLES-1; otherwise it SHALL enter IDLE.
REQ-015 P=1 while in ON or GAP SHALL increment pend, saturating at MAX_PEND.
REQ-016 P=1 while pend==MAX_PEND, with no same-cycle dequeue, SHALL leave pend unchanged and set ovf to 1.
REQ-017 Leaving GAP for ON SHALL decrement pend by 1 when pend>0.
REQ-018 If P=1 in the same cycle as that dequeue, pend SHALL stay unchanged (net zero) and ovf SHALL NOT set.
REQ-019 If pend==0 and P=1 at the GAP-exit cycle, the FSM SHALL go directly to ON and pend SHALL remain 0.
REQ-020 P held high for N consecutive cycles SHALL count as N events; the upstream conditioner is responsible for single-cycle pulses.
REQ-021 The counter SHALL be wide enough for max(ON_CYCLES, GAP_CYCLES)-1 and SHALL never wrap below 0.
REQ-022 ovf SHALL clear only on reset.

Reset
REQ-023 With reset=1 at an edge: state=IDLE, counter=0, L=0, busy=0, pend=0, ovf=0.
REQ-024 Reset SHALL take priority over P and over any in-progress ON or GAP. Queued events are discarded.
REQ-025 A P that arrives in the same cycle as reset SHALL be ignored.
REQ-026 In the first cycle after reset deasserts, the block SHALL accept P as a normal IDLE event.

Configuration
REQ-027 Macro PULSE_INDICATOR_QUEUE_EN, when defined, SHALL enable queueing per REQ-015..REQ-019.
REQ-028 When PULSE_INDICATOR_QUEUE_EN is undefined:
- P in ON or GAP SHALL be dropped.
- pend SHALL be tied to 0 and ovf to 0.
- GAP exit SHALL go to ON only if P=1 that cycle; otherwise it goes to IDLE.
- All other behaviour is unchanged.

Verification
REQ-029 Defaults; single P pulse sampled at edge 0 -> L=1 during cycles 1..8, L=0 during 9..12, busy=0 from cycle 13, pend=0 throughout.
REQ-030 QUEUE_EN; pulses at edges 0, 3 and 5 -> pend steps 1 then 2; three 8-cycle L highs separated by exactly 4 low cycles; pend=0 after the third starts; ovf=0.
REQ-031 QUEUE_EN; P held high 10 cycles starting at edge 0 -> pend saturates at 7, ovf=1 and stays 1 after the queue drains; exactly 8 L highs total.
REQ-032 QUEUE_EN; pend=1 and P=1 on the GAP-exit cycle -> ON re-entered, pend stays 1, ovf=0.
REQ-033 Reset asserted for 1 cycle mid-ON with pend=3 -> next cycle L=0, busy=0, pend=0, ovf=0; a following P restarts a full 8-cycle L high.
REQ-034 Macro undefined; pulses at edges 0 and 3 -> only one 8-cycle L high and pend=0 throughout.

Source files
------------

// File: rtl/pulse_indicator_if.sv
// pulse_indicator_if: event pulse in, indicator level and queue status out.
// master drives the event pulse; slave is the indicator block.
interface pulse_indicator_if;
    logic       P;
    logic       L;
    logic       busy;
    logic [7:0] pend;
    logic       ovf;

    modport master (output P, input  L, busy, pend, ovf);
    modport slave  (input  P, output L, busy, pend, ovf);
endinterface

// File: rtl/pulse_indicator.sv
// pulse_indicator: stretches one-cycle event pulses into human-visible
// ON_CYCLES-long highs on L, each followed by at least GAP_CYCLES low.
// Optional macro PULSE_INDICATOR_QUEUE_EN: events arriving while busy are
// queued (up to MAX_PEND) instead of dropped; ovf flags a lost event.
module pulse_indicator #(
    parameter int ON_CYCLES  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_PEND   = 7
) (
    input  logic               clk,
    input  logic               reset,
    pulse_indicator_if.slave   io_bus
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (ON_CYCLES < 1 || GAP_CYCLES < 1 || MAX_PEND < 1 || MAX_PEND > 255) begin : g_bad_param
        $error("pulse_indicator: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_L;
    logic             r_busy;

    logic w_cnt_zero;
    logic w_gap_exit;
    logic w_pend_nz;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_gap_exit = (r_state == GAP) && w_cnt_zero;

`ifdef PULSE_INDICATOR_QUEUE_EN
    localparam logic [7:0] PEND_MAX = 8'(MAX_PEND);

    logic [7:0] r_pend;
    logic       r_ovf;
    logic       w_enq;
    logic       w_deq;

    assign w_pend_nz = (r_pend != 8'd0);
    // A queued event is consumed whenever GAP runs out with something waiting.
    assign w_deq     = w_gap_exit && w_pend_nz;
    // P while busy is queued, except at a GAP exit with an empty queue,
    // where it is displayed immediately instead.
    assign w_enq     = io_bus.P && (r_state != IDLE) && !(w_gap_exit && !w_pend_nz);

    // Pending-event queue depth and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 8'd0;
            r_ovf  <= 1'b0;
        end else if (w_deq && !w_enq) begin
            r_pend <= r_pend - 8'd1;
        end else if (w_enq && !w_deq) begin
            if (r_pend == PEND_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_pend <= r_pend + 8'd1;
            end
        end
    end

    assign io_bus.pend = r_pend;
    assign io_bus.ovf  = r_ovf;
`else
    assign w_pend_nz   = 1'b0;
    assign io_bus.pend = 8'd0;
    assign io_bus.ovf  = 1'b0;
`endif

    // IDLE/ON/GAP sequencer with registered L and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_L     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (io_bus.P) begin
                        r_state <= ON;
                        r_cnt   <= ON_LOAD;
                        r_L     <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ON: begin
                    if (w_cnt_zero) begin
                        r_state <= GAP;
                        r_cnt   <= GAP_LOAD;
                        r_L     <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (w_cnt_zero) begin
                        if (w_pend_nz || io_bus.P) begin
                            r_state <= ON;
                            r_cnt   <= ON_LOAD;
                            r_L     <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_L     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.L    = r_L;
    assign io_bus.busy = r_busy;

endmodule

// File: tb/tb_pulse_indicator.sv
// tb_pulse_indicator: table vectors, directed corner sequences and random
// traffic against a timeline-based reference model of the indicator.
module tb_pulse_indicator;

    localparam int ON   = 8;
    localparam int GAP  = 4;
    localparam int MAXP = 7;
`ifdef PULSE_INDICATOR_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pulse_indicator_if bus ();

    pulse_indicator #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .MAX_PEND  (MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an event display occupies edges [start, start+ON+GAP);
    // the edge start+ON+GAP decides whether a new display begins there.
    int t = 0;
    bit m_act = 1'b0;
    int m_start = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;

    int rises = 0;
    int hi_cnt = 0;
    logic prev_L = 1'b0;

    function automatic void model_edge(input bit p, input bit r);
        if (r) begin
            m_act = 1'b0; m_pend = 0; m_ovf = 1'b0;
        end else if (!m_act) begin
            if (p) begin m_act = 1'b1; m_start = t; end
        end else if (t == m_start + ON + GAP) begin
            if (m_pend > 0) begin
                m_start = t;
                if (!p) m_pend--;
            end else if (p) begin
                m_start = t;
            end else begin
                m_act = 1'b0;
            end
        end else if (p && QEN) begin
            if (m_pend < MAXP) m_pend++;
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic bit m_L();
        return m_act && ((t - m_start) < ON);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // One clock edge: drive, clock, update model, sample 1 time unit later.
    task automatic step(input bit p, input bit r);
        bus.P = p;
        reset = r;
        @(posedge clk);
        t++;
        model_edge(p, r);
        #1;
        chk("model", {21'd0, bus.L, bus.busy, bus.pend, bus.ovf},
            {21'd0, m_L(), m_act, 8'(m_pend), m_ovf});
        if (bus.L === 1'b1 && prev_L !== 1'b1) rises++;
        if (bus.L === 1'b1) hi_cnt++;
        prev_L = bus.L;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        rises = 0;
        hi_cnt = 0;
    endtask

    typedef struct {
        bit       p;
        bit       exp_L;
        bit       exp_busy;
        bit [7:0] exp_pend;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Single pulse after reset: L high after edges 0..7, busy through edge 11.
        for (int i = 0; i < 16; i++) begin
            tbl[i].p        = (i == 0);
            tbl[i].exp_L    = (i <= 7);
            tbl[i].exp_busy = (i <= 11);
            tbl[i].exp_pend = 8'd0;
        end

        bus.P = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_state", {28'd0, bus.L, bus.busy, bus.ovf, 1'b0}, 32'd0);
        chk("reset_pend", {24'd0, bus.pend}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].p, 1'b0);
            chk("tbl_L", {31'd0, bus.L}, {31'd0, tbl[i].exp_L});
            chk("tbl_busy", {31'd0, bus.busy}, {31'd0, tbl[i].exp_busy});
            chk("tbl_pend", {24'd0, bus.pend}, {24'd0, tbl[i].exp_pend});
        end

        // P coincident with reset is ignored.
        step(1'b1, 1'b1);
        chk("rst_with_P_busy", {31'd0, bus.busy}, 32'd0);
        step(1'b0, 1'b0);
        chk("rst_with_P_idle", {31'd0, bus.busy}, 32'd0);

`ifdef PULSE_INDICATOR_QUEUE_EN
        // Pulses at edges 0, 3, 5: three displays, queue steps 1 then 2.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(i == 0 || i == 3 || i == 5, 1'b0);
            if (i == 3)  chk("q3_pend1", {24'd0, bus.pend}, 32'd1);
            if (i == 5)  chk("q3_pend2", {24'd0, bus.pend}, 32'd2);
            if (i == 24) chk("q3_pend0", {24'd0, bus.pend}, 32'd0);
        end
        chk("q3_rises", rises, 32'd3);
        chk("q3_ovf", {31'd0, bus.ovf}, 32'd0);

        // P held 10 cycles: saturate and overflow, 8 displays total.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("sat_pend", {24'd0, bus.pend}, MAXP);
        chk("sat_ovf", {31'd0, bus.ovf}, 32'd1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        chk("sat_drain_pend", {24'd0, bus.pend}, 32'd0);
        chk("sat_ovf_sticky", {31'd0, bus.ovf}, 32'd1);
        chk("sat_rises", rises, 32'd8);

        // pend=1 and P on the GAP-exit edge: net-zero queue change.
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 2; i < 12; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("exit_P_L", {31'd0, bus.L}, 32'd1);
        chk("exit_P_pend", {24'd0, bus.pend}, 32'd1);
        chk("exit_P_ovf", {31'd0, bus.ovf}, 32'd0);

        // Reset mid-ON with pend=3 discards everything; next P is a full display.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("midrst_pend3", {24'd0, bus.pend}, 32'd3);
        step(1'b0, 1'b1);
        chk("midrst_clear", {21'd0, bus.L, bus.busy, bus.pend, bus.ovf}, 32'd0);
        hi_cnt = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0);
        chk("midrst_full_high", hi_cnt, ON);
`else
        // Without queueing, a pulse while busy is dropped.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(i == 0 || i == 3, 1'b0);
            if (i == 3) chk("noq_pend", {24'd0, bus.pend}, 32'd0);
        end
        chk("noq_rises", rises, 32'd1);
        chk("noq_high", hi_cnt, ON);
`endif

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
